// File: rtl/msrv32_pkg.sv
//==============================================================================
// Module      : msrv32_pkg
// Description : Shared opcode, funct3 and 2-bit predictor counter encodings.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package msrv32_pkg;

    // Opcode field opcode[6:2]
    localparam logic [4:0] c_OP_BRANCH = 5'b11000;
    localparam logic [4:0] c_OP_JAL    = 5'b11011;
    localparam logic [4:0] c_OP_JALR   = 5'b11001;

    localparam logic [2:0] c_F3_BEQ  = 3'b000;
    localparam logic [2:0] c_F3_BNE  = 3'b001;
    localparam logic [2:0] c_F3_BLT  = 3'b100;
    localparam logic [2:0] c_F3_BGE  = 3'b101;
    localparam logic [2:0] c_F3_BLTU = 3'b110;
    localparam logic [2:0] c_F3_BGEU = 3'b111;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t c_SNT = 2'b00;
    localparam bht_cnt_t c_WNT = 2'b01;
    localparam bht_cnt_t c_WT  = 2'b10;
    localparam bht_cnt_t c_ST  = 2'b11;

    // Saturating step of a 2-bit counter towards the resolved direction
    function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic taken);
        if (taken) begin
            return (cnt == c_ST) ? c_ST : bht_cnt_t'(cnt + 2'b01);
        end
        return (cnt == c_SNT) ? c_SNT : bht_cnt_t'(cnt - 2'b01);
    endfunction

endpackage

`default_nettype wire

// File: rtl/msrv32_branch_cmp.sv
//==============================================================================
// Module      : msrv32_branch_cmp
// Description : Combinational branch condition evaluator for branches and jumps.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module msrv32_branch_cmp
    import msrv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [4:0]      i_opcode,
    input  logic [2:0]      i_funct3,
    output logic            o_taken,
    output logic            o_cond_branch
);

    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = (i_rs1 == i_rs2);
    assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
    assign w_ltu = (i_rs1 < i_rs2);

    // o_cond_branch flags only conditional branches with a legal funct3
    always_comb begin
        o_taken       = 1'b0;
        o_cond_branch = 1'b0;
        case (i_opcode)
            c_OP_BRANCH: begin
                o_cond_branch = 1'b1;
                case (i_funct3)
                    c_F3_BEQ:  o_taken = w_eq;
                    c_F3_BNE:  o_taken = ~w_eq;
                    c_F3_BLT:  o_taken = w_lt;
                    c_F3_BGE:  o_taken = ~w_lt;
                    c_F3_BLTU: o_taken = w_ltu;
                    c_F3_BGEU: o_taken = ~w_ltu;
                    default:   o_cond_branch = 1'b0;
                endcase
            end
            c_OP_JAL, c_OP_JALR: o_taken = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/msrv32_branch_predict_unit.sv
//==============================================================================
// Module      : msrv32_branch_predict_unit
// Description : Bimodal branch predictor with resolve stage and statistics.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module msrv32_branch_predict_unit
    import msrv32_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 16
) (
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_in,
    input  logic [XLEN-1:0]  fetch_pc_in,
    output logic             predict_taken_out,
    input  logic             resolve_valid_in,
    input  logic [XLEN-1:0]  resolve_pc_in,
    input  logic [XLEN-1:0]  rs1_in,
    input  logic [XLEN-1:0]  rs2_in,
    input  logic [6:0]       opcode_in,
    input  logic [2:0]       funct3_in,
    input  logic             predicted_taken_in,
    input  logic             stall_in,
    input  logic             flush_in,
    output logic             branch_taken_out,
    output logic             resolve_valid_out,
    output logic             mispredict_out,
    output logic [CNT_W-1:0] branch_count_out,
    output logic [CNT_W-1:0] mispredict_count_out
);

    localparam int IDX = $clog2(BHT_DEPTH);

    logic [IDX-1:0]         w_fetch_idx;
    logic [IDX-1:0]         w_resolve_idx;
    logic                   w_taken;
    logic                   w_cond_branch;
    logic                   w_mispredict;
    logic                   w_update_en;
    logic                   w_advance;
    logic [2*BHT_DEPTH-1:0] w_bht_flat;
    logic                   w_unused_bits;

    logic                   r_valid;
    logic                   r_taken;
    logic                   r_mispredict;
    logic [CNT_W-1:0]       r_branch_cnt;
    logic [CNT_W-1:0]       r_mispredict_cnt;

    assign w_fetch_idx   = fetch_pc_in[IDX+1:2];
    assign w_resolve_idx = resolve_pc_in[IDX+1:2];

    // PC bits outside the index and the opcode length bits carry no information here
    assign w_unused_bits = ^{fetch_pc_in[XLEN-1:IDX+2], fetch_pc_in[1:0],
                             resolve_pc_in[XLEN-1:IDX+2], resolve_pc_in[1:0],
                             opcode_in[1:0]};

    msrv32_branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .i_rs1         (rs1_in),
        .i_rs2         (rs2_in),
        .i_opcode      (opcode_in[6:2]),
        .i_funct3      (funct3_in),
        .o_taken       (w_taken),
        .o_cond_branch (w_cond_branch)
    );

    assign w_mispredict = resolve_valid_in & (w_taken ^ predicted_taken_in);
    assign w_advance    = ~flush_in & ~stall_in;
    assign w_update_en  = w_advance & resolve_valid_in & w_cond_branch;

    // One flop pair per entry so the asynchronous reset reaches every counter
    generate
        for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
            bht_cnt_t r_cnt;

            always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
                if (ms_riscv32_mp_rst_in) begin
                    r_cnt <= c_WNT;
                end else if (w_update_en && (w_resolve_idx == IDX'(gi))) begin
                    r_cnt <= bht_next(r_cnt, w_taken);
                end
            end

            assign w_bht_flat[2*gi +: 2] = r_cnt;
        end
    endgenerate

    // Lookup sees the pre-update value when it collides with a same-cycle update
    assign predict_taken_out = ~ms_riscv32_mp_rst_in & w_bht_flat[{w_fetch_idx, 1'b1}];

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_valid      <= 1'b0;
            r_taken      <= 1'b0;
            r_mispredict <= 1'b0;
        end else if (flush_in) begin
            r_valid      <= 1'b0;
            r_taken      <= 1'b0;
            r_mispredict <= 1'b0;
        end else if (!stall_in) begin
            r_valid      <= resolve_valid_in;
            r_taken      <= resolve_valid_in & w_taken;
            r_mispredict <= w_mispredict;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (w_update_en && (r_branch_cnt != {CNT_W{1'b1}})) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_advance && w_mispredict && (r_mispredict_cnt != {CNT_W{1'b1}})) begin
                r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
            end
        end
    end

    assign branch_taken_out     = r_taken;
    assign resolve_valid_out    = r_valid;
    assign mispredict_out       = r_mispredict;
    assign branch_count_out     = r_branch_cnt;
    assign mispredict_count_out = r_mispredict_cnt;

endmodule

`default_nettype wire

// File: doc/msrv32_branch_predict_unit.md
MSRV32_BRANCH_PREDICT_UNIT -- requirements
Module: msrv32_branch_predict_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and PC width.
REQ-002 SHALL have parameter BHT_DEPTH, default 64, number of 2-bit counters; power of two, minimum 4.
REQ-003 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-004 SHALL have ports:
- ms_riscv32_mp_clk_in, input, 1: clock, rising edge.
- ms_riscv32_mp_rst_in, input, 1: reset, asynchronous, active-high.
- fetch_pc_in, input, XLEN: PC being fetched, for the prediction lookup.
- predict_taken_out, output, 1: prediction for fetch_pc_in.
- resolve_valid_in, input, 1: resolve-stage instruction is valid.
- resolve_pc_in, input, XLEN: PC of the resolving instruction.
- rs1_in, input, XLEN: source operand 1.
- rs2_in, input, XLEN: source operand 2.
- opcode_in, input, 7: instruction opcode.
- funct3_in, input, 3: branch condition.
- predicted_taken_in, input, 1: prediction made at fetch for this instruction.
- stall_in, input, 1: hold the output register.
- flush_in, input, 1: kill the output register contents.
- branch_taken_out, output, 1: registered resolved outcome.
- resolve_valid_out, output, 1: registered valid.
- mispredict_out, output, 1: registered mispredict.
- branch_count_out, output, CNT_W: resolved conditional branches.
- mispredict_count_out, output, CNT_W: mispredicts.

Function
REQ-005 SHALL compute taken combinationally, decoded on opcode_in[6:2]:
- 11000 (conditional branch), by funct3:
  - 000: rs1 == rs2.
  - 001: rs1 != rs2.
  - 100: signed rs1 < rs2.
  - 101: signed rs1 >= rs2.
  - 110: unsigned rs1 < rs2.
  - 111: unsigned rs1 >= rs2.
  - 010 and 011: 0.
- 11011 (JAL) and 11001 (JALR): 1.
- Any other opcode: 0.
REQ-006 SHALL index the table with pc[IDX+1:2], where IDX = log2(BHT_DEPTH); PC bits [1:0] are ignored.
REQ-007 SHALL drive predict_taken_out combinationally from bit 1 of the counter at the fetch_pc_in index.
REQ-008 SHALL treat a JAL or JALR opcode at fetch_pc_in as unknown: prediction comes from the table only; the fetch stage handles jumps.
REQ-009 SHALL update the counter at the resolve_pc_in index on a clock edge only when all of the following hold: resolve_valid_in=1, opcode is a conditional branch, funct3 is legal, stall_in=0.
REQ-010 SHALL update that counter as follows:
- taken: increment, saturating at 11.
- not taken: decrement, saturating at 00.
REQ-011 SHALL NOT update the table for JAL, JALR or illegal funct3.
REQ-012 SHALL return the pre-update counter value when a lookup and an update hit the same index in the same cycle; there is no bypass.
REQ-013 SHALL compute mispredict combinationally as valid AND (taken XOR predicted_taken_in); this applies to jumps too.
REQ-014 SHALL register branch_taken_out, mispredict_out and resolve_valid_out one cycle after the inputs (latency 1).
REQ-015 SHALL hold all registered outputs and the table when stall_in=1.
REQ-016 SHALL apply flush_in=1 on the next edge as follows:
- resolve_valid_out and mispredict_out go to 0.
- branch_taken_out goes to 0.
- No table update and no statistics update happen that cycle.
- flush overrides stall.
REQ-017 SHALL force mispredict_out=0 and branch_taken_out=0 in the register whenever the registered valid is 0.
REQ-018 SHALL increment branch_count_out once per table update.
REQ-019 SHALL increment mispredict_count_out once per registered mispredict that is not stalled or flushed, covering conditional branches and jumps.
REQ-020 SHALL saturate both statistics counters at all-ones; they never wrap.

Reset
REQ-021 SHALL, on ms_riscv32_mp_rst_in=1, immediately and independently of the clock:
- set every table counter to 01 (weakly not taken);
- set all registered outputs and both statistics counters to 0.
REQ-022 SHALL drive predict_taken_out=0 during reset.
REQ-023 SHALL, on reset asserted mid-operation, discard any in-flight result with no update.

Structure
REQ-024 SHALL place the opcode constants (BRANCH, JAL, JALR), the funct3 encodings and the counter encodings (SNT=00, WNT=01, WT=10, ST=11) in shared package msrv32_pkg.
REQ-025 SHALL implement the comparator as combinational sub-module msrv32_branch_cmp, parametrised by XLEN.
REQ-026 SHALL implement the table as a flop array so that asynchronous reset initialises every entry.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- Signed/unsigned compare: rs1=0xFFFFFFFF, rs2=1 with BLT -> taken=1; same operands with BLTU -> taken=0; BEQ with equal operands -> 1.
- Saturation: one PC taken 4 times in a row -> counter 01->10->11->11, predict_taken_out=1; then not taken 3 times -> 00, predict=0.
- Same-cycle hazard: fetch and resolve on the same PC with counter 01, resolve taken -> predict_taken_out=0 that cycle, 1 the next.
- Mispredict: BNE taken with predicted_taken_in=0 -> one cycle later mispredict_out=1 and mispredict_count_out increments by 1; JAL with predicted_taken_in=0 -> mispredict_out=1 and no table change.
- Stall and flush: stall_in=1 for 3 cycles -> outputs and counts frozen; flush_in together with stall_in -> resolve_valid_out=0 next cycle.
- Reset: asynchronous reset asserted between edges -> outputs 0 immediately; after release, every index predicts 0 and one taken update flips that index to predict 1.
